aska_npg: RTL and testbench
===========================

// Module: aska_npg
// PURPOSE
//  Neuromuscular pulse generator for the ASKA stimulator digital core.
//  - Emits charge-balanced biphasic current pulses between two one-hot electrode groups.
//  - Pulses are grouped into ON bursts (ramped amplitude) and OFF pauses.
//  - Drives the H-bridge up/down switch lines and a 6-bit amplitude level for the current DAC.
// PARAMETERS
//  GAP_CYCLES  1   interphase gap length in clk cycles (>=1)
//  ACC_W       16  ramp accumulator width; 4 fractional bits
// PORTS
//  clk            in   1   system clock (20 kHz nominal; 1 cycle = 50 us)
//  resetn         in   1   asynchronous, active-high reset (asserted = 1)
//  freq           in   12  pulse period = freq+1 clk cycles
//  phaseDuration  in   3   width of each phase = phaseDuration+1 cycles
//  ramp           in   6   number of ON pulses spent ramping up (0 treated as 1)
//  ramp_factor    in   10  level increment per ramp pulse, U6.4
//  ON_time        in   8   pulses per ON burst
//  OFF_time       in   10  silent periods per OFF pause
//  electrode1     in   4   one-hot anode group (phase A source)
//  electrode2     in   4   one-hot cathode group (phase A sink)
//  enable         in   1   run stimulation
//  up_switches    out  4   high-side switch enables
//  down_switches  out  4   low-side switch enables
//  level          out  6   current DAC amplitude code
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, all counters and accumulator cleared.
//  - FSM states: IDLE, PHASE_A, GAP, PHASE_B, WAIT. Counters: cyc (period), pcnt (pulse in cycle), burst flag.
//  - IDLE -> PHASE_A on the first clk edge with enable=1; cyc=0, ON burst starts, acc=0.
//  - PHASE_A (pd+1 cycles): up_switches=electrode1, down_switches=electrode2.
//  - GAP (GAP_CYCLES): both switch buses 0.
//  - PHASE_B (pd+1 cycles): up_switches=electrode2, down_switches=electrode1.
//  - WAIT: switches 0 until cyc==freq, then cyc wraps to 0 and the next period starts.
//  - Minimum period: if freq+1 < 2*(pd+1)+GAP_CYCLES, the next period starts the cycle after PHASE_B ends (no truncation).
//  - Burst: ON = ON_time pulsing periods, then OFF = OFF_time silent periods (FSM stays in WAIT), repeat.
//  - ON_time=0: every period silent. OFF_time=0: ON bursts run back to back.
//  - Ramp: at the start of ON pulse k (k=0..), if k < max(ramp,1): acc += ramp_factor, saturating at 63<<4; otherwise acc holds.
//  - level = acc[9:4], registered, updated on PHASE_A entry.
//  - Each new ON burst clears acc before pulse 0's increment.
//  - level is 0 whenever the FSM is not in PHASE_A/GAP/PHASE_B.
//  - Safety: if electrode1==0, electrode2==0 or (electrode1&electrode2)!=0, the pulse runs silently (switches 0); timing is unaffected.
//  - Inputs are sampled at each period start; mid-pulse changes take effect next period.
//  - enable=0: next edge -> IDLE, switches and level 0 (a pulse in progress is aborted).
//  - resetn mid-pulse: outputs 0 immediately (asynchronous).
// CONFIGURATION
//  RAMP_DOWN_EN defined:
//   - The last max(ramp,1) pulses of each ON burst decrement acc by ramp_factor (floor 0), giving a symmetric trapezoid.
//   - If ON_time < 2*ramp, ramp-down takes priority once reached.
//  RAMP_DOWN_EN undefined: level holds its plateau to the end of the burst, then drops to 0.
// TESTING
//  - freq=49, pd=3, electrode1=4, electrode2=1, enable=1 -> period 50 cycles; up=4/down=1 for 4 cycles, 1 gap, up=1/down=4 for 4 cycles.
//  - ramp=50, ramp_factor=16 -> level 1,2,...,50 on pulses 0..49, then 50 constant.
//  - ON_time=3, OFF_time=2, freq=49 -> 3 pulsing periods, 2 silent (100 cycles), repeat; acc restarts at ramp_factor.
//  - electrode1=electrode2=2 -> switches stay 0 while period timing continues.
//  - enable dropped during PHASE_B -> next edge switches=0, level=0; re-enable restarts with level=ramp_factor>>4.
//  - resetn=1 pulse mid-PHASE_A -> outputs 0 asynchronously; restart from IDLE after release.

Source files
------------

// File: rtl/aska_npg.sv
// rtl/aska_npg.sv - ASKA biphasic neuromuscular pulse generator with burst and ramp control.
// Optional: define RAMP_DOWN_EN for a symmetric ramp-down at the end of each ON burst.
module aska_npg #(
  parameter int GAP_CYCLES = 1,
  parameter int ACC_W      = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] freq,
  input  logic [2:0]  phaseDuration,
  input  logic [5:0]  ramp,
  input  logic [9:0]  ramp_factor,
  input  logic [7:0]  ON_time,
  input  logic [9:0]  OFF_time,
  input  logic [3:0]  electrode1,
  input  logic [3:0]  electrode2,
  input  logic        enable,
  output logic [3:0]  up_switches,
  output logic [3:0]  down_switches,
  output logic [5:0]  level
);

  typedef enum logic [2:0] {IDLE, PHASE_A, GAP, PHASE_B, WAIT} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(63 << 4);

  state_t           state;
  logic [15:0]      cyc;
  logic [15:0]      ph;
  logic [11:0]      freq_l;
  logic [2:0]       pd_l;
  logic [3:0]       e1_l;
  logic [3:0]       e2_l;
  logic             valid_l;
  logic             on_phase;
  logic [9:0]       cnt;
  logic [ACC_W-1:0] acc;

  logic             eff_on;
  logic [9:0]       eff_cnt;
  logic             ps_pulse;
  logic [7:0]       ps_k;
  logic             ps_on;
  logic [9:0]       ps_cnt;
  logic [5:0]       r_eff;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_new;
  logic             valid_in;
  logic             period_done;
  logic             start_now;

  // Burst bookkeeping for the period about to start; IDLE always opens a fresh ON burst.
  always_comb begin
    eff_on   = (state == IDLE) ? 1'b1 : on_phase;
    eff_cnt  = (state == IDLE) ? 10'd0 : cnt;
    ps_pulse = 1'b0;
    ps_k     = 8'd0;
    ps_on    = eff_on;
    ps_cnt   = eff_cnt;
    if (eff_on && (eff_cnt < {2'b00, ON_time})) begin
      ps_pulse = 1'b1;
      ps_k     = eff_cnt[7:0];
      ps_cnt   = eff_cnt + 10'd1;
    end else if (eff_on ? (OFF_time == 10'd0) : (eff_cnt >= OFF_time)) begin
      if (ON_time != 8'd0) begin
        ps_pulse = 1'b1;
        ps_on    = 1'b1;
        ps_cnt   = 10'd1;
      end else if (OFF_time != 10'd0) begin
        ps_on  = 1'b0;
        ps_cnt = 10'd1;
      end else begin
        ps_on  = 1'b1;
        ps_cnt = 10'd0;
      end
    end else begin
      ps_on  = 1'b0;
      ps_cnt = eff_on ? 10'd1 : eff_cnt + 10'd1;
    end
  end

  // Ramp accumulator step applied at the start of each ON pulse.
  always_comb begin
    r_eff    = (ramp == 6'd0) ? 6'd1 : ramp;
    acc_base = (ps_k == 8'd0) ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(ramp_factor);
    acc_new  = acc_base;
    if ({2'b00, r_eff} > ps_k)
      acc_new = (acc_sum > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum[ACC_W-1:0];
`ifdef RAMP_DOWN_EN
    if (({1'b0, ps_k} + {3'b000, r_eff}) >= {1'b0, ON_time})
      acc_new = (acc_base > ACC_W'(ramp_factor)) ? acc_base - ACC_W'(ramp_factor) : '0;
`else
`endif
  end

  always_comb begin
    valid_in    = (electrode1 != 4'd0) && (electrode2 != 4'd0) &&
                  ((electrode1 & electrode2) == 4'd0);
    period_done = (cyc >= {4'b0000, freq_l});
    start_now   = enable && ((state == IDLE) ||
                             (state == WAIT && period_done) ||
                             (state == PHASE_B && ph == {13'd0, pd_l} && period_done));
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state         <= IDLE;
      cyc           <= '0;
      ph            <= '0;
      freq_l        <= '0;
      pd_l          <= '0;
      e1_l          <= '0;
      e2_l          <= '0;
      valid_l       <= 1'b0;
      on_phase      <= 1'b0;
      cnt           <= '0;
      acc           <= '0;
      up_switches   <= '0;
      down_switches <= '0;
      level         <= '0;
    end else if (!enable) begin
      state         <= IDLE;
      cyc           <= '0;
      ph            <= '0;
      up_switches   <= '0;
      down_switches <= '0;
      level         <= '0;
    end else if (start_now) begin
      cyc      <= '0;
      ph       <= '0;
      freq_l   <= freq;
      pd_l     <= phaseDuration;
      e1_l     <= electrode1;
      e2_l     <= electrode2;
      valid_l  <= valid_in;
      on_phase <= ps_on;
      cnt      <= ps_cnt;
      if (ps_pulse) begin
        state         <= PHASE_A;
        acc           <= acc_new;
        level         <= acc_new[9:4];
        up_switches   <= valid_in ? electrode1 : 4'd0;
        down_switches <= valid_in ? electrode2 : 4'd0;
      end else begin
        state         <= WAIT;
        level         <= '0;
        up_switches   <= '0;
        down_switches <= '0;
      end
    end else begin
      cyc <= cyc + 16'd1;
      case (state)
        PHASE_A: begin
          if (ph == {13'd0, pd_l}) begin
            state         <= GAP;
            ph            <= '0;
            up_switches   <= '0;
            down_switches <= '0;
          end else begin
            ph <= ph + 16'd1;
          end
        end
        GAP: begin
          if (ph == 16'(GAP_CYCLES - 1)) begin
            state         <= PHASE_B;
            ph            <= '0;
            up_switches   <= valid_l ? e2_l : 4'd0;
            down_switches <= valid_l ? e1_l : 4'd0;
          end else begin
            ph <= ph + 16'd1;
          end
        end
        PHASE_B: begin
          if (ph == {13'd0, pd_l}) begin
            state         <= WAIT;
            ph            <= '0;
            up_switches   <= '0;
            down_switches <= '0;
            level         <= '0;
          end else begin
            ph <= ph + 16'd1;
          end
        end
        WAIT: begin
          ph <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aska_npg.sv
// tb/tb_aska_npg.sv - directed self-checking bench for aska_npg.
module tb_aska_npg;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] freq;
  logic [2:0]  phaseDuration;
  logic [5:0]  ramp;
  logic [9:0]  ramp_factor;
  logic [7:0]  ON_time;
  logic [9:0]  OFF_time;
  logic [3:0]  electrode1;
  logic [3:0]  electrode2;
  logic        enable;
  logic [3:0]  up_switches;
  logic [3:0]  down_switches;
  logic [5:0]  level;

  int n_checks = 0;
  int n_fails  = 0;

  aska_npg #(.GAP_CYCLES(1), .ACC_W(16)) dut (
    .clk(clk), .resetn(resetn), .freq(freq), .phaseDuration(phaseDuration),
    .ramp(ramp), .ramp_factor(ramp_factor), .ON_time(ON_time), .OFF_time(OFF_time),
    .electrode1(electrode1), .electrode2(electrode2), .enable(enable),
    .up_switches(up_switches), .down_switches(down_switches), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the edge that enters PHASE_A of period 0.
  task automatic restart();
    enable = 1'b0;
    resetn = 1'b1;
    tick(2);
    resetn = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
  endtask

  initial begin
    resetn = 1'b1; enable = 1'b0;
    freq = 12'd49; phaseDuration = 3'd3; ramp = 6'd50; ramp_factor = 10'd16;
    ON_time = 8'd255; OFF_time = 10'd0; electrode1 = 4'd4; electrode2 = 4'd1;
    tick(2);
    check("reset_up", 16'(up_switches), 16'd0);
    check("reset_down", 16'(down_switches), 16'd0);
    check("reset_level", 16'(level), 16'd0);

    // Basic pulse shape and ramp
    restart();
    check("pa_up", 16'(up_switches), 16'd4);
    check("pa_down", 16'(down_switches), 16'd1);
    check("pa_level", 16'(level), 16'd1);
    tick(3);
    check("pa_last_up", 16'(up_switches), 16'd4);
    tick(1);
    check("gap_up", 16'(up_switches), 16'd0);
    check("gap_down", 16'(down_switches), 16'd0);
    check("gap_level", 16'(level), 16'd1);
    tick(1);
    check("pb_up", 16'(up_switches), 16'd1);
    check("pb_down", 16'(down_switches), 16'd4);
    tick(3);
    check("pb_last_up", 16'(up_switches), 16'd1);
    tick(1);
    check("wait_up", 16'(up_switches), 16'd0);
    check("wait_level", 16'(level), 16'd0);
    tick(40);
    check("wait_end_up", 16'(up_switches), 16'd0);
    tick(1);
    check("p1_up", 16'(up_switches), 16'd4);
    check("p1_level", 16'(level), 16'd2);
    for (int k = 2; k <= 54; k++) begin
      tick(50);
      check("ramp_level", 16'(level), 16'((k + 1 > 50) ? 50 : k + 1));
    end

    // Burst ON=3 / OFF=2
    ON_time = 8'd3; OFF_time = 10'd2;
    restart();
    for (int p = 0; p < 10; p++) begin
      check("burst_up", 16'(up_switches), 16'(((p % 5) < 3) ? 4 : 0));
      check("burst_level", 16'(level), 16'(((p % 5) < 3) ? (p % 5) + 1 : 0));
      tick(2);
      check("burst_mid_up", 16'(up_switches), 16'(((p % 5) < 3) ? 4 : 0));
      tick(48);
    end

    // Invalid electrode pair keeps switches off; timing and sampling continue
    ON_time = 8'd255; OFF_time = 10'd0;
    electrode1 = 4'd2; electrode2 = 4'd2;
    restart();
    check("safe_up", 16'(up_switches), 16'd0);
    check("safe_down", 16'(down_switches), 16'd0);
    tick(6);
    check("safe_pb_up", 16'(up_switches), 16'd0);
    electrode1 = 4'd4; electrode2 = 4'd1;
    tick(1);
    check("midchange_up", 16'(up_switches), 16'd0);
    tick(43);
    check("safe_next_up", 16'(up_switches), 16'd4);
    check("safe_next_down", 16'(down_switches), 16'd1);
    check("safe_next_level", 16'(level), 16'd2);

    // Disable during PHASE_B
    tick(6);
    check("dis_pb_up", 16'(up_switches), 16'd1);
    enable = 1'b0;
    tick(1);
    check("dis_up", 16'(up_switches), 16'd0);
    check("dis_down", 16'(down_switches), 16'd0);
    check("dis_level", 16'(level), 16'd0);
    tick(3);
    check("dis_hold_level", 16'(level), 16'd0);
    enable = 1'b1;
    tick(1);
    check("reen_up", 16'(up_switches), 16'd4);
    check("reen_level", 16'(level), 16'd1);

    // Asynchronous reset mid-PHASE_A
    tick(2);
    #2 resetn = 1'b1;
    #1;
    check("arst_up", 16'(up_switches), 16'd0);
    check("arst_down", 16'(down_switches), 16'd0);
    check("arst_level", 16'(level), 16'd0);
    tick(1);
    resetn = 1'b0;
    tick(1);
    check("arst_restart_up", 16'(up_switches), 16'd4);
    check("arst_restart_level", 16'(level), 16'd1);

    // Period shorter than the pulse: next period follows PHASE_B directly
    freq = 12'd3;
    restart();
    tick(8);
    check("short_pb_up", 16'(up_switches), 16'd1);
    tick(1);
    check("short_next_up", 16'(up_switches), 16'd4);
    check("short_next_level", 16'(level), 16'd2);

    // ON_time = 0: every period silent
    ON_time = 8'd0;
    restart();
    check("on0_up", 16'(up_switches), 16'd0);
    check("on0_level", 16'(level), 16'd0);
    tick(5);
    check("on0_later_up", 16'(up_switches), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
